// File: rtl/jtframe_trace_trig.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_trace_trig : frame-triggered trace capture into an FWFT FIFO  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module jtframe_trace_trig #(
  parameter int CH = 4,
  parameter int DW = 16,
  parameter int AW = 9,
  parameter int FW = 16,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vs,
  input  logic               downloading,
  input  logic [1:0]         mode,
  input  logic [FW-1:0]      start_frame,
  input  logic [FW-1:0]      frame_len,
  input  logic               arm,
  input  logic               stop,
  input  logic [CH-1:0]      ch_mask,
  input  logic [CH-1:0]      ch_valid,
  input  logic [CH*DW-1:0]   ch_data,
  output logic [FW-1:0]      frame_cnt,
  output logic               dump_on,
  output logic [1:0]         state,
  output logic               lost,
  output logic               rd_valid,
  output logic [DW+CHW-1:0]  rd_data,
  input  logic               rd_ready,
  output logic [AW:0]        fill
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] c_FULL = {1'b1, {AW{1'b0}}};

  state_t               r_state;
  logic                 r_dump_on;
  logic                 r_vs_l;
  logic                 r_dl_l;
  logic [FW-1:0]        r_frame_cnt;
  logic [FW-1:0]        r_win_cnt;
  logic                 r_lost;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_fill;
  logic [DW+CHW-1:0]    r_mem [2**AW];

  logic                 w_vs_fall;
  logic                 w_dl_fall;
  logic [FW-1:0]        w_frame_nxt;
  logic [FW-1:0]        w_win_nxt;
  logic                 w_clear;
  logic [CH-1:0]        w_qual;
  logic [CHW-1:0]       w_sel;
  logic [DW-1:0]        w_sel_data;
  logic                 w_multi;
  logic                 w_push_try;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;

  assign w_vs_fall   = r_vs_l & ~vs;
  assign w_dl_fall   = r_dl_l & ~downloading;
  assign w_frame_nxt = r_frame_cnt + FW'(1);
  assign w_win_nxt   = r_win_cnt + FW'(1);

  // arm only takes effect where it actually leaves IDLE/DONE for ARMED
  assign w_clear = arm && ((r_state == S_IDLE && !stop) || r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dump_on   <= 1'b0;
      r_vs_l      <= vs;
      r_dl_l      <= downloading;
      r_frame_cnt <= '0;
      r_win_cnt   <= '0;
    end else begin
      r_vs_l <= vs;
      r_dl_l <= downloading;
      if (w_vs_fall) r_frame_cnt <= w_frame_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_clear) r_state <= S_ARMED;
        end
        S_ARMED: begin
          r_win_cnt <= '0;
          if (stop) begin
            r_state <= S_IDLE;
          end else if ((mode == 2'd1 && w_vs_fall && w_frame_nxt == start_frame) ||
                       (mode == 2'd2 && w_dl_fall) ||
                       (mode == 2'd0 || mode == 2'd3)) begin
            r_state   <= S_CAPTURE;
            r_dump_on <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_vs_fall) r_win_cnt <= w_win_nxt;
          if (stop || (w_vs_fall && frame_len != '0 && w_win_nxt == frame_len)) begin
            r_state   <= S_DONE;
            r_dump_on <= 1'b0;
          end
        end
        default: begin
          if (w_clear) r_state <= S_ARMED;
        end
      endcase
    end
  end

  // lowest qualifying channel wins; any other qualifying channel is a loss
  always_comb begin
    w_sel      = '0;
    w_sel_data = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_qual[i]) begin
        w_sel      = CHW'(i);
        w_sel_data = ch_data[i*DW +: DW];
      end
    end
  end

  assign w_qual     = ch_valid & ch_mask;
  assign w_multi    = |(w_qual & (w_qual - CH'(1)));
  assign w_push_try = (r_state == S_CAPTURE) && (|w_qual);
  assign w_full     = (r_fill == c_FULL);
  assign w_pop      = rd_ready && rd_valid;
  assign w_push     = w_push_try && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_lost   <= 1'b0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_lost   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (AW+1)'(1);
      else if (!w_push && w_pop) r_fill <= r_fill - (AW+1)'(1);
      if (w_push_try && (w_multi || (w_full && !w_pop))) r_lost <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= {w_sel, w_sel_data};
  end

  assign frame_cnt = r_frame_cnt;
  assign dump_on   = r_dump_on;
  assign state     = r_state;
  assign lost      = r_lost;
  assign fill      = r_fill;
  assign rd_valid  = (r_fill != '0);
  assign rd_data   = rd_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_trace_trig.sv
`default_nettype none
// Bench for jtframe_trace_trig: directed stimulus, FIFO output checked by a scoreboard monitor.
module tb_jtframe_trace_trig;

  localparam int CH  = 4;
  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int FW  = 4;
  localparam int CHW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vs;
  logic               downloading;
  logic [1:0]         mode;
  logic [FW-1:0]      start_frame;
  logic [FW-1:0]      frame_len;
  logic               arm;
  logic               stop;
  logic [CH-1:0]      ch_mask;
  logic [CH-1:0]      ch_valid;
  logic [CH*DW-1:0]   ch_data;
  logic [FW-1:0]      frame_cnt;
  logic               dump_on;
  logic [1:0]         state;
  logic               lost;
  logic               rd_valid;
  logic [DW+CHW-1:0]  rd_data;
  logic               rd_ready;
  logic [AW:0]        fill;

  int checks = 0;
  int errors = 0;
  logic [DW+CHW-1:0] exp_q[$];

  jtframe_trace_trig #(.CH(CH), .DW(DW), .AW(AW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .mode(mode),
    .start_frame(start_frame), .frame_len(frame_len), .arm(arm), .stop(stop),
    .ch_mask(ch_mask), .ch_valid(ch_valid), .ch_data(ch_data),
    .frame_cnt(frame_cnt), .dump_on(dump_on), .state(state), .lost(lost),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every accepted pop against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0h expected none", rd_data);
        end else begin
          logic [DW+CHW-1:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(2); rst_n = 1'b1;
  endtask

  // One channel-0 sample; accepted samples go into the scoreboard.
  task automatic write0(input logic [DW-1:0] d, input bit accepted, input bit with_pop = 1'b0);
    ch_mask = 4'b0001; ch_valid = 4'b0001; ch_data = '0; ch_data[DW-1:0] = d;
    rd_ready = with_pop;
    if (accepted) exp_q.push_back({2'd0, d});
    step();
    ch_valid = '0; rd_ready = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vs = 1'b0; downloading = 1'b0; mode = 2'd0; start_frame = '0; frame_len = '0;
    arm = 1'b0; stop = 1'b0; ch_mask = '0; ch_valid = '0; ch_data = '0; rd_ready = 1'b0;
    do_reset();
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_state",     32'(state), 0);
    chk("rst_dump_on",   32'(dump_on), 0);
    chk("rst_fill",      32'(fill), 0);
    chk("rst_lost",      32'(lost), 0);
    chk("rst_rd_valid",  32'(rd_valid), 0);
    chk("rst_rd_data",   32'(rd_data), 0);

    // frame counter and wrap at 2**FW
    repeat (5) frame();
    chk("cnt_5", 32'(frame_cnt), 5);
    repeat (12) frame();
    chk("cnt_wrap_17", 32'(frame_cnt), 1);

    // frame trigger: start at 3, length 2
    do_reset();
    mode = 2'd1; start_frame = 4'd3; frame_len = 4'd2;
    pulse_arm();
    chk("ft_armed", 32'(state), 1);
    frame(); frame();
    chk("ft_f2_state", 32'(state), 1);
    chk("ft_f2_dump", 32'(dump_on), 0);
    frame();
    chk("ft_f3_state", 32'(state), 2);
    chk("ft_f3_dump", 32'(dump_on), 1);
    frame();
    chk("ft_f4_state", 32'(state), 2);
    frame();
    chk("ft_f5_state", 32'(state), 3);
    chk("ft_f5_dump", 32'(dump_on), 0);

    // download trigger
    mode = 2'd2;
    pulse_arm();
    downloading = 1'b1; step(2);
    chk("dl_wait", 32'(state), 1);
    downloading = 1'b0; step();
    chk("dl_capture", 32'(state), 2);
    pulse_stop();
    chk("dl_stop", 32'(state), 3);

    // channel priority
    mode = 2'd0;
    pulse_arm(); step();
    chk("pri_capture", 32'(state), 2);
    ch_mask = 4'b1110; ch_valid = 4'b0110;
    ch_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    exp_q.push_back({2'd1, 16'hA001});
    step();
    ch_valid = '0;
    chk("pri_fill", 32'(fill), 1);
    chk("pri_lost", 32'(lost), 1);
    pop_one();
    chk("pri_drained", 32'(fill), 0);

    // overflow of a 4-entry FIFO
    pulse_stop(); pulse_arm();
    chk("ov_lost_cleared", 32'(lost), 0);
    step();
    for (int k = 0; k < 5; k++) write0(16'h1000 + 16'(k), k < 4);
    chk("ov_fill", 32'(fill), 4);
    chk("ov_lost", 32'(lost), 1);
    repeat (4) pop_one();
    chk("ov_empty", 32'(fill), 0);

    // push and pop together while full
    pulse_stop(); pulse_arm(); step();
    for (int k = 5; k < 9; k++) write0(16'h1000 + 16'(k), 1'b1);
    chk("pp_full", 32'(fill), 4);
    chk("pp_lost_before", 32'(lost), 0);
    write0(16'h1009, 1'b1, 1'b1);
    chk("pp_fill", 32'(fill), 4);
    chk("pp_lost_after", 32'(lost), 0);
    repeat (4) pop_one();
    chk("pp_drained", 32'(fill), 0);

    // unbounded capture, stop, re-arm, reset mid-capture
    pulse_stop(); frame_len = '0; pulse_arm(); step();
    repeat (100) frame();
    chk("ub_state", 32'(state), 2);
    chk("ub_dump", 32'(dump_on), 1);
    ch_mask = 4'b0011; ch_valid = 4'b0011; step(); ch_valid = '0;
    chk("ub_fill", 32'(fill), 1);
    chk("ub_lost", 32'(lost), 1);
    pulse_stop();
    chk("ub_stop_state", 32'(state), 3);
    chk("ub_stop_dump", 32'(dump_on), 0);
    pulse_arm();
    chk("rearm_state", 32'(state), 1);
    chk("rearm_fill", 32'(fill), 0);
    chk("rearm_lost", 32'(lost), 0);
    step();
    write0(16'h2222, 1'b0);
    chk("mid_fill", 32'(fill), 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_dump", 32'(dump_on), 0);
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_cnt", 32'(frame_cnt), 0);

    step(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
